mux_scan_sequencer: RTL and testbench

//  Upstream control stage for the 4-to-1 mux bank. Drives the shared 2-bit select
//  S through 00,01,10,11, waits a settle time per slot, samples the mux output(s)
//  and presents all four sampled values as one registered word with a done pulse.

---
 rtl/mux_scan_sequencer.sv | 154 +++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sequencer
// Description : Steps the shared 2-bit mux select through 00..11, waits a settle
//               time per slot, captures the mux lane(s) and publishes all four
//               samples as one registered word with a one-cycle done pulse.
//               Optional macro MUX_SCAN_CONTINUOUS_EN adds the cont input for
//               back-to-back scans.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer #(
    parameter int WIDTH         = 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
`ifdef MUX_SCAN_CONTINUOUS_EN
    input  logic                 cont,
`endif
    input  logic [WIDTH-1:0]     mux_out,
    output logic [1:0]           s,
    output logic [4*WIDTH-1:0]   data,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_SAMPLE = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [1:0] c_LAST_SLOT   = 2'b11;

    logic [1:0]           r_state;
    logic [1:0]           r_s;
    logic [3:0]           r_cnt;
    logic [4*WIDTH-1:0]   r_shadow;
    logic [4*WIDTH-1:0]   r_data;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_cont;
    logic                 w_done_busy;
    logic [4*WIDTH-1:0]   w_capture;

`ifdef MUX_SCAN_CONTINUOUS_EN
    assign w_cont      = cont;
    // Busy stays up across the done cycle so a streaming consumer sees no gap.
    assign w_done_busy = 1'b1;
`else
    assign w_cont      = 1'b0;
    assign w_done_busy = 1'b0;
`endif

    // Shadow with the current slot replaced by the live lane value, so the
    // last slot's sample can be published on the same edge it is captured.
    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_slot
            assign w_capture[k*WIDTH +: WIDTH] =
                (r_s == 2'(k)) ? mux_out : r_shadow[k*WIDTH +: WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_s      <= 2'b00;
            r_cnt    <= 4'd0;
            r_shadow <= '0;
            r_data   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_s <= 2'b00;
                    if (start && !abort) begin
                        r_state  <= c_ST_SETTLE;
                        r_cnt    <= c_SETTLE_LOAD;
                        r_shadow <= '0;
                        r_busy   <= 1'b1;
                    end
                end

                c_ST_SETTLE: begin
                    if (abort) begin
                        r_state  <= c_ST_IDLE;
                        r_s      <= 2'b00;
                        r_shadow <= '0;
                        r_busy   <= 1'b0;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= c_ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                c_ST_SAMPLE: begin
                    if (abort) begin
                        r_state  <= c_ST_IDLE;
                        r_s      <= 2'b00;
                        r_shadow <= '0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_shadow <= w_capture;
                        if (r_s == c_LAST_SLOT) begin
                            r_state <= c_ST_DONE;
                            r_data  <= w_capture;
                            r_done  <= 1'b1;
                            r_busy  <= w_done_busy;
                        end else begin
                            // Select only moves here, giving the mux a full
                            // settle window before the next capture.
                            r_s     <= r_s + 2'd1;
                            r_cnt   <= c_SETTLE_LOAD;
                            r_state <= c_ST_SETTLE;
                        end
                    end
                end

                c_ST_DONE: begin
                    r_s <= 2'b00;
                    if (w_cont && !abort) begin
                        r_state  <= c_ST_SETTLE;
                        r_cnt    <= c_SETTLE_LOAD;
                        r_shadow <= '0;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_s     <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s    = r_s;
    assign data = r_data;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_sequencer
// Description : Self-checking bench for mux_scan_sequencer; DONE-time data is
//               checked against a queue of expected words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [3:0] pat_a = 4'b0000, pat_b = 4'b0000;
    logic       mux_a, mux_b;
    logic [1:0] s_a, s_b;
    logic [3:0] data_a, data_b;
    logic       busy_a, busy_b, done_a, done_b;

    // The "mux bank": lane value is a fixed pattern indexed by the select.
    assign mux_a = pat_a[s_a];
    assign mux_b = pat_b[s_b];

    int total = 0;
    int bad   = 0;
    logic [3:0] q_a[$];
    logic [3:0] q_b[$];

    typedef struct {
        logic [3:0] pat;
        logic [3:0] exp_data;
        int         restart_at;
        bit         abort_in_done;
    } vec_t;
    vec_t vecs[5];

    mux_scan_sequencer #(.WIDTH(1), .SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
`ifdef MUX_SCAN_CONTINUOUS_EN
        .cont(1'b0),
`endif
        .mux_out(mux_a), .s(s_a), .data(data_a), .busy(busy_a), .done(done_a)
    );

    mux_scan_sequencer #(.WIDTH(1), .SETTLE_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
`ifdef MUX_SCAN_CONTINUOUS_EN
        .cont(1'b0),
`endif
        .mux_out(mux_b), .s(s_b), .data(data_b), .busy(busy_b), .done(done_b)
    );

`ifdef MUX_SCAN_CONTINUOUS_EN
    logic       start_c = 1'b0, abort_c = 1'b0, cont_c = 1'b0;
    logic [7:0] lane_c = 8'b10_01_00_11;
    logic [1:0] mux_c, s_c;
    logic [7:0] data_c;
    logic       busy_c, done_c;
    logic [7:0] q_c[$];
    assign mux_c = lane_c[s_c*2 +: 2];

    mux_scan_sequencer #(.WIDTH(2), .SETTLE_CYCLES(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .cont(cont_c),
        .mux_out(mux_c), .s(s_c), .data(data_c), .busy(busy_c), .done(done_c)
    );
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every DONE must match a queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_a === 1'b1) begin
                chk("done_a_expected", 32'(q_a.size() > 0), 1);
                if (q_a.size() > 0) chk("data_a_at_done", data_a, q_a.pop_front());
            end
            if (done_b === 1'b1) begin
                chk("done_b_expected", 32'(q_b.size() > 0), 1);
                if (q_b.size() > 0) chk("data_b_at_done", data_b, q_b.pop_front());
            end
`ifdef MUX_SCAN_CONTINUOUS_EN
            if (done_c === 1'b1) begin
                chk("done_c_expected", 32'(q_c.size() > 0), 1);
                if (q_c.size() > 0) chk("data_c_at_done", data_c, q_c.pop_front());
            end
`endif
        end
    end

    task automatic run_scan(input bit use_b, input logic [3:0] pat, input logic [3:0] exp_data,
                            input int exp_lat, input int slot_len, input int restart_at,
                            input bit abort_in_done);
        int n;
        bit s_ok;
        n = 0;
        s_ok = 1'b1;
        if (use_b) begin pat_b = pat; start_b = 1'b1; q_b.push_back(exp_data); end
        else       begin pat_a = pat; start_a = 1'b1; q_a.push_back(exp_data); end
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        chk("busy_after_accept", use_b ? busy_b : busy_a, 1);
        while ((use_b ? done_b : done_a) !== 1'b1 && n < 60) begin
            if ((use_b ? s_b : s_a) !== 2'(n / slot_len)) s_ok = 1'b0;
            if (n == restart_at) begin
                start_a = !use_b;
                start_b = use_b;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            step();
            n++;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        chk("done_latency", n, exp_lat);
        chk("s_sequence", s_ok, 1);
        chk("busy_in_done", use_b ? busy_b : busy_a, 0);
        chk("s_in_done", use_b ? s_b : s_a, 3);
        chk("data_in_done", use_b ? data_b : data_a, exp_data);
        if (abort_in_done) begin
            if (use_b) abort_b = 1'b1; else abort_a = 1'b1;
        end
        step();
        abort_a = 1'b0;
        abort_b = 1'b0;
        chk("done_one_cycle", use_b ? done_b : done_a, 0);
        chk("s_back_to_00", use_b ? s_b : s_a, 0);
        chk("data_holds", use_b ? data_b : data_a, exp_data);
    endtask

    initial begin
        int n;
        vecs[0] = '{pat: 4'b1101, exp_data: 4'b1101, restart_at: -1, abort_in_done: 1'b0};
        vecs[1] = '{pat: 4'b0000, exp_data: 4'b0000, restart_at: -1, abort_in_done: 1'b0};
        vecs[2] = '{pat: 4'b1111, exp_data: 4'b1111, restart_at: 5,  abort_in_done: 1'b1};
        vecs[3] = '{pat: 4'b0110, exp_data: 4'b0110, restart_at: 10, abort_in_done: 1'b0};
        vecs[4] = '{pat: 4'b1010, exp_data: 4'b1010, restart_at: -1, abort_in_done: 1'b0};

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_s", s_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_b_data", data_b, 0);
        rst = 1'b0;
        step();

        // Table-driven scans on the SETTLE_CYCLES=1 instance
        for (int i = 0; i < 5; i++) begin
            run_scan(1'b0, vecs[i].pat, vecs[i].exp_data, 12, 3,
                     vecs[i].restart_at, vecs[i].abort_in_done);
            step();
        end

        // SETTLE_CYCLES=0: 8-cycle scan, START while busy ignored
        run_scan(1'b1, 4'b1010, 4'b1010, 8, 2, 3, 1'b0);
        repeat (12) step();
        chk("b_single_done", q_b.size(), 0);

        // ABORT at S=10 after a completed 1010 scan
        pat_a = 4'b0101;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n = 0;
        while (s_a !== 2'b10 && n < 40) begin step(); n++; end
        chk("reach_s10", s_a, 2);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_s", s_a, 0);
        chk("abort_data", data_a, 4'b1010);
        repeat (20) step();
        chk("abort_data_later", data_a, 4'b1010);
        chk("abort_busy_later", busy_a, 0);

        // START and ABORT together in IDLE
        start_a = 1'b1;
        abort_a = 1'b1;
        step();
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("start_abort_busy", busy_a, 0);
        step();
        chk("start_abort_busy2", busy_a, 0);

        // Reset mid-scan at S=01
        pat_a = 4'b1111;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n = 0;
        while (s_a !== 2'b01 && n < 40) begin step(); n++; end
        chk("reach_s01", s_a, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_s", s_a, 0);
        chk("midrst_data", data_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        repeat (20) step();
        chk("midrst_busy_later", busy_a, 0);

`ifdef MUX_SCAN_CONTINUOUS_EN
        // Continuous mode, WIDTH=2, two passes then stop
        cont_c = 1'b1;
        start_c = 1'b1;
        q_c.push_back(8'b10_01_00_11);
        q_c.push_back(8'b10_01_00_11);
        step();
        start_c = 1'b0;
        n = 0;
        while (done_c !== 1'b1 && n < 60) begin step(); n++; end
        chk("cont_first_latency", n, 12);
        chk("cont_busy_in_done", busy_c, 1);
        n = 0;
        do begin step(); n++; end while (done_c !== 1'b1 && n < 60);
        chk("cont_period", n, 13);
        chk("cont_busy_in_done2", busy_c, 1);
        cont_c = 1'b0;
        step();
        chk("cont_stop_busy", busy_c, 0);
        chk("cont_stop_s", s_c, 0);
        repeat (20) step();
        chk("q_c_drained", q_c.size(), 0);
`endif

        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
